// File: rtl/bus_arbiter_split.sv
// Two-master bus arbiter with split-slave suspend/resume and a tenure watchdog.
// Define ARB_RR_EN for round-robin tie-breaking; otherwise master 1 wins ties.
module bus_arbiter_split #(
  parameter int TENURE_MAX = 64,
  parameter int CNT_WIDTH  = $clog2(TENURE_MAX) + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic breq1,
  input  logic breq2,
  input  logic sready1,
  input  logic sready2,
  input  logic sreadysp,
  input  logic ssplit,
  output logic bgrant1,
  output logic bgrant2,
  output logic msel,
  output logic msplit1,
  output logic msplit2,
  output logic split_grant,
  output logic arb_timeout
);

  typedef enum logic [1:0] {IDLE, GNT1, GNT2} state_t;

  state_t state_q, state_d;
  logic bgrant1_q, bgrant1_d;
  logic bgrant2_q, bgrant2_d;
  logic msel_q, msel_d;
  logic msplit1_q, msplit1_d;
  logic msplit2_q, msplit2_d;
  logic split_grant_q, split_grant_d;
  logic arb_timeout_q, arb_timeout_d;
  logic split_pend_q, split_pend_d;
  logic split_owner_q, split_owner_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
`ifdef ARB_RR_EN
  // 1 = master 2 received the last new grant; reset value lets master 1 win first
  logic rr_last_q, rr_last_d;
`endif

  logic req1, req2, pick2, own2, own_req, leave;

  always_comb begin
    state_d       = state_q;
    bgrant1_d     = bgrant1_q;
    bgrant2_d     = bgrant2_q;
    msel_d        = msel_q;
    msplit1_d     = msplit1_q;
    msplit2_d     = msplit2_q;
    split_grant_d = split_grant_q;
    arb_timeout_d = 1'b0;
    split_pend_d  = split_pend_q;
    split_owner_d = split_owner_q;
    cnt_d         = cnt_q;
`ifdef ARB_RR_EN
    rr_last_d     = rr_last_q;
`endif
    req1    = breq1 & ~msplit1_q;
    req2    = breq2 & ~msplit2_q;
    pick2   = 1'b0;
    own2    = (state_q == GNT2);
    own_req = own2 ? breq2 : breq1;
    leave   = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        // A pending split resume outranks any new request and ignores slave readiness
        if (split_pend_q && sreadysp) begin
          split_pend_d  = 1'b0;
          split_grant_d = 1'b1;
          msel_d        = split_owner_q;
          if (split_owner_q) begin
            state_d   = GNT2;
            bgrant2_d = 1'b1;
            msplit2_d = 1'b0;
          end else begin
            state_d   = GNT1;
            bgrant1_d = 1'b1;
            msplit1_d = 1'b0;
          end
        end else if (sready1 && sready2 && (req1 || req2)) begin
`ifdef ARB_RR_EN
          pick2     = req2 && (!req1 || !rr_last_q);
          rr_last_d = pick2;
`else
          pick2     = req2 && !req1;
`endif
          state_d       = pick2 ? GNT2 : GNT1;
          bgrant1_d     = !pick2;
          bgrant2_d     = pick2;
          msel_d        = pick2;
          split_grant_d = 1'b0;
        end
      end
      GNT1, GNT2: begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
        if (ssplit && !split_pend_q) begin
          leave         = 1'b1;
          split_pend_d  = 1'b1;
          split_owner_d = own2;
          if (own2) msplit2_d = 1'b1;
          else      msplit1_d = 1'b1;
        end else if (!own_req) begin
          leave = 1'b1;
        end else if (cnt_q == CNT_WIDTH'(TENURE_MAX - 1)) begin
          leave         = 1'b1;
          arb_timeout_d = 1'b1;
        end
        // Every exit passes through IDLE, which guarantees the dead cycle on handover
        if (leave) begin
          state_d       = IDLE;
          bgrant1_d     = 1'b0;
          bgrant2_d     = 1'b0;
          split_grant_d = 1'b0;
          cnt_d         = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      bgrant1_q     <= 1'b0;
      bgrant2_q     <= 1'b0;
      msel_q        <= 1'b0;
      msplit1_q     <= 1'b0;
      msplit2_q     <= 1'b0;
      split_grant_q <= 1'b0;
      arb_timeout_q <= 1'b0;
      split_pend_q  <= 1'b0;
      split_owner_q <= 1'b0;
      cnt_q         <= '0;
`ifdef ARB_RR_EN
      rr_last_q     <= 1'b1;
`endif
    end else begin
      state_q       <= state_d;
      bgrant1_q     <= bgrant1_d;
      bgrant2_q     <= bgrant2_d;
      msel_q        <= msel_d;
      msplit1_q     <= msplit1_d;
      msplit2_q     <= msplit2_d;
      split_grant_q <= split_grant_d;
      arb_timeout_q <= arb_timeout_d;
      split_pend_q  <= split_pend_d;
      split_owner_q <= split_owner_d;
      cnt_q         <= cnt_d;
`ifdef ARB_RR_EN
      rr_last_q     <= rr_last_d;
`endif
    end
  end

  assign bgrant1     = bgrant1_q;
  assign bgrant2     = bgrant2_q;
  assign msel        = msel_q;
  assign msplit1     = msplit1_q;
  assign msplit2     = msplit2_q;
  assign split_grant = split_grant_q;
  assign arb_timeout = arb_timeout_q;

endmodule

// File: tb/tb_bus_arbiter_split.sv
// Scoreboard bench for bus_arbiter_split (TENURE_MAX=8); inputs packed as
// {rst,breq1,breq2,sready1,sready2,sreadysp,ssplit}, outputs as
// {bgrant1,bgrant2,msel,msplit1,msplit2,split_grant,arb_timeout}.
module tb_bus_arbiter_split;

  logic clk = 1'b0;
  logic rst, breq1, breq2, sready1, sready2, sreadysp, ssplit;
  logic bgrant1, bgrant2, msel, msplit1, msplit2, split_grant, arb_timeout;

  int checks = 0;
  int errors = 0;
  logic [6:0] exp_q[$];

  always #5 clk = ~clk;

  bus_arbiter_split #(.TENURE_MAX(8)) dut (
    .clk(clk), .rst(rst), .breq1(breq1), .breq2(breq2),
    .sready1(sready1), .sready2(sready2), .sreadysp(sreadysp), .ssplit(ssplit),
    .bgrant1(bgrant1), .bgrant2(bgrant2), .msel(msel), .msplit1(msplit1),
    .msplit2(msplit2), .split_grant(split_grant), .arb_timeout(arb_timeout)
  );

  function automatic logic [6:0] outs();
    return {bgrant1, bgrant2, msel, msplit1, msplit2, split_grant, arb_timeout};
  endfunction

  // Drive one cycle of inputs at the falling edge and queue the expected registered outputs
  task automatic drive(input logic [6:0] stim, input logic [6:0] expv);
    @(negedge clk);
    {rst, breq1, breq2, sready1, sready2, sreadysp, ssplit} = stim;
    exp_q.push_back(expv);
  endtask

  task automatic test_reset();
    logic [6:0] e;
    for (int i = 0; i < 2; i++) begin
      drive(7'b1001100, 7'b0000000);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (outs() !== e) begin
        errors++;
        $display("[TB] FAIL reset step %0d: got %b expected %b", i, outs(), e);
      end
    end
  endtask

  task automatic test_basic_grant();
    logic [6:0] stim[5];
    logic [6:0] expt[5];
    logic [6:0] e;
    stim = '{7'b0111100, 7'b0111100, 7'b0011100, 7'b0011100, 7'b0001100};
    expt = '{7'b1000000, 7'b1000000, 7'b0000000, 7'b0110000, 7'b0010000};
    for (int i = 0; i < 5; i++) begin
      drive(stim[i], expt[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (outs() !== e) begin
        errors++;
        $display("[TB] FAIL basic_grant step %0d: got %b expected %b", i, outs(), e);
      end
    end
  endtask

  task automatic test_split();
    logic [6:0] stim[9];
    logic [6:0] expt[9];
    logic [6:0] e;
    stim = '{7'b0101100, 7'b0101100, 7'b0111101, 7'b0111100, 7'b0111101,
             7'b0101100, 7'b0101110, 7'b0101100, 7'b0001100};
    expt = '{7'b1000000, 7'b1000000, 7'b0001000, 7'b0111000, 7'b0111000,
             7'b0011000, 7'b1000010, 7'b1000010, 7'b0000000};
    for (int i = 0; i < 9; i++) begin
      drive(stim[i], expt[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (outs() !== e) begin
        errors++;
        $display("[TB] FAIL split step %0d: got %b expected %b", i, outs(), e);
      end
    end
  endtask

  task automatic test_resume_priority();
    logic [6:0] stim[5];
    logic [6:0] expt[5];
    logic [6:0] e;
    stim = '{7'b0011100, 7'b0011101, 7'b0111110, 7'b0101100, 7'b0001101};
    expt = '{7'b0110000, 7'b0010100, 7'b0110010, 7'b0010000, 7'b0010000};
    for (int i = 0; i < 5; i++) begin
      drive(stim[i], expt[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (outs() !== e) begin
        errors++;
        $display("[TB] FAIL resume_priority step %0d: got %b expected %b", i, outs(), e);
      end
    end
  endtask

  task automatic test_ready_gating();
    logic [6:0] e;
    for (int i = 0; i < 12; i++) begin
      if (i < 10)       drive(7'b0100100, 7'b0010000);
      else if (i == 10) drive(7'b0101100, 7'b1000000);
      else              drive(7'b0001100, 7'b0000000);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (outs() !== e) begin
        errors++;
        $display("[TB] FAIL ready_gating step %0d: got %b expected %b", i, outs(), e);
      end
    end
  endtask

  task automatic test_watchdog();
    logic [6:0] e;
    for (int k = 1; k <= 21; k++) begin
      if (k == 21)                drive(7'b0001100, 7'b0010000);
      else if (k == 9 || k == 18) drive(7'b0011100, 7'b0010001);
      else                        drive(7'b0011100, 7'b0110000);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (outs() !== e) begin
        errors++;
        $display("[TB] FAIL watchdog step %0d: got %b expected %b", k, outs(), e);
      end
    end
  endtask

  task automatic test_reset_mid_split();
    logic [6:0] stim[5];
    logic [6:0] expt[5];
    logic [6:0] e;
    stim = '{7'b0101100, 7'b0101101, 7'b0111100, 7'b1111100, 7'b0001110};
    expt = '{7'b1000000, 7'b0001000, 7'b0111000, 7'b0000000, 7'b0000000};
    for (int i = 0; i < 5; i++) begin
      drive(stim[i], expt[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (outs() !== e) begin
        errors++;
        $display("[TB] FAIL reset_mid_split step %0d: got %b expected %b", i, outs(), e);
      end
    end
  endtask

  // Both masters contend; the current owner releases after three grant cycles
  task automatic test_back_to_back();
    logic w;
    logic [6:0] g, e;
    for (int t = 0; t < 3; t++) begin
`ifdef ARB_RR_EN
      w = t[0];
`else
      w = 1'b0;
`endif
      g = w ? 7'b0110000 : 7'b1000000;
      for (int c = 0; c < 4; c++) begin
        if (c < 3) drive(7'b0111100, g);
        else       drive(w ? 7'b0101100 : 7'b0011100, {2'b00, w, 4'b0000});
        @(posedge clk); #1;
        e = exp_q.pop_front();
        checks++;
        if (outs() !== e) begin
          errors++;
          $display("[TB] FAIL back_to_back tenure %0d cycle %0d: got %b expected %b", t, c, outs(), e);
        end
      end
    end
  endtask

  initial begin
    {rst, breq1, breq2, sready1, sready2, sreadysp, ssplit} = 7'b1000000;
    test_reset();
    test_basic_grant();
    test_split();
    test_resume_priority();
    test_ready_gating();
    test_watchdog();
    test_reset_mid_split();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout: got running expected finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
